// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with write bypass and busy scoreboard
//
// Purpose: architectural register file for the pipelined datapath. One writeback
// port, NUM_RD combinational decode read ports, and a per-register busy
// scoreboard that stalls issue on RAW (source pending) or WAW (destination
// pending) hazards.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset (registers and busy cleared)
//   RegWr     in   writeback write enable
//   Rw        in   writeback destination register
//   busW      in   writeback data
//   Ra        in   read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   busR      out  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_used   in   per-port flag: address is a real operand
//   issue_en  in   decode requests issue
//   issue_wr  in   issuing instruction writes a register
//   Rd_issue  in   issuing instruction's destination
//   stall     out  issue blocked this cycle (combinational)
//   busy      out  scoreboard, bit r = register r has a pending write

module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RegWr,
    input  logic [ADDR_WIDTH-1:0]        Rw,
    input  logic [DATA_WIDTH-1:0]        busW,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] Ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] busR,
    input  logic [NUM_RD-1:0]            rd_used,
    input  logic                         issue_en,
    input  logic                         issue_wr,
    input  logic [ADDR_WIDTH-1:0]        Rd_issue,
    output logic                         stall,
    output logic [NUM_REGS-1:0]          busy
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;

    logic                  w_wr_en;
    logic [NUM_RD-1:0]     w_raw;
    logic                  w_waw;
    logic                  w_set_ok;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_clr_mask;

    // A write to the hardwired zero register never lands and never forwards.
    assign w_wr_en = RegWr && !((ZERO_REG != 0) && (Rw == '0));

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic                  w_fwd;
        logic                  w_hit;

        assign w_ra  = Ra[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_hit = RegWr && (Rw == w_ra);
        assign w_fwd = (BYPASS != 0) && w_wr_en && (Rw == w_ra);

        assign busR[gi*DATA_WIDTH +: DATA_WIDTH] =
            w_fwd                               ? busW :
            ((ZERO_REG != 0) && (w_ra == '0))   ? '0   :
                                                  r_regs[w_ra];

        // Without bypass the arriving value is not visible until the next
        // edge, so a same-cycle writeback cannot resolve the hazard.
        assign w_raw[gi] = rd_used[gi] && r_busy[w_ra] && !((BYPASS != 0) && w_hit);
    end

    // A writeback landing this cycle retires the old producer, so a new
    // producer for the same register may issue alongside it.
    assign w_waw = issue_wr && r_busy[Rd_issue] && !(RegWr && (Rw == Rd_issue));

    assign stall = issue_en && ((|w_raw) || w_waw);

    assign w_set_ok   = issue_en && !stall && issue_wr &&
                        !((ZERO_REG != 0) && (Rd_issue == '0));
    assign w_set_mask = w_set_ok ? (NUM_REGS'(1) << Rd_issue) : '0;
    assign w_clr_mask = RegWr    ? (NUM_REGS'(1) << Rw)       : '0;

    assign busy = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[Rw] <= busW;
        end
    end

    // Set is applied after clear so a new producer keeps the register busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

endmodule
